// File: rtl/fp_mult_exc_pipe_if.sv
// Handshake bundle between the multiplier datapath, the exception stage and its consumer.
// The slave side is the exception stage itself.
interface fp_mult_exc_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [2:0]   rnd_mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z_calc;
    logic         overflow;
    logic         underflow;
    logic         inexact;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         zero_f;
    logic         inf_f;
    logic         nan_f;
    logic         tiny_f;
    logic         huge_f;
    logic         inexact_f;

    modport master (
        output rnd_mode, in_valid, a, b, z_calc, overflow, underflow, inexact, out_ready,
        input  in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f
    );

    modport slave (
        input  rnd_mode, in_valid, a, b, z_calc, overflow, underflow, inexact, out_ready,
        output in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f
    );
endinterface

// File: rtl/fp_mult_exc_pipe.sv
// Registered multiplier exception stage: special-case / overflow / underflow resolution
// under a run-time rounding mode, valid/ready output register, sticky flags and counter.
module fp_mult_exc_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sticky_clr,
    output logic [5:0]        sticky_flags,
    output logic [CNT_W-1:0]  exc_count,
    fp_mult_exc_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    logic             ready_en_reg;
    logic             out_valid_reg;
    logic [W-1:0]     z_reg;
    logic [5:0]       flags_reg;
    logic [5:0]       sticky_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    logic accept;
    logic xfer;
    logic exc_bit;

    logic [EXP_W-1:0] a_exp, b_exp, zc_exp;
    logic [MAN_W-1:0] a_man, b_man, zc_man;
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic sign;
    logic [2:0] mode;
    logic ovf_to_inf;
    logic unf_to_min;

    logic [W-1:0] qnan_c, inf_c, max_c, min_c, zero_c;
    logic [W-1:0] res_z;
    logic         res_nan, res_tiny, res_huge, res_inx, res_zero, res_inf;
    logic [5:0]   res_flags;

    // Ready stays low through reset and for the first edge after it.
    assign bus.in_ready = ready_en_reg && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = out_valid_reg && bus.out_ready;

    assign a_exp  = bus.a[W-2 -: EXP_W];
    assign b_exp  = bus.b[W-2 -: EXP_W];
    assign zc_exp = bus.z_calc[W-2 -: EXP_W];
    assign a_man  = bus.a[MAN_W-1:0];
    assign b_man  = bus.b[MAN_W-1:0];
    assign zc_man = bus.z_calc[MAN_W-1:0];

    // Denormal operands are flushed, so any zero exponent counts as zero.
    assign a_zero = (a_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    assign b_zero = (b_exp == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

    assign sign = bus.a[W-1] ^ bus.b[W-1];
    assign mode = (bus.rnd_mode > 3'd5) ? 3'd0 : bus.rnd_mode;

    assign ovf_to_inf = (mode == 3'd1) ? 1'b0 :
                        (mode == 3'd2) ? !sign :
                        (mode == 3'd3) ? sign : 1'b1;
    assign unf_to_min = (mode == 3'd5) ? 1'b1 :
                        (mode == 3'd2) ? !sign :
                        (mode == 3'd3) ? sign : 1'b0;

    assign qnan_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    assign inf_c  = {sign, EXP_ONES, {MAN_W{1'b0}}};
    assign max_c  = {sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
    assign min_c  = {sign, {{(EXP_W-1){1'b0}}, 1'b1}, {MAN_W{1'b0}}};
    assign zero_c = {sign, {(W-1){1'b0}}};

    always_comb begin
        res_z    = bus.z_calc;
        res_nan  = 1'b0;
        res_tiny = 1'b0;
        res_huge = 1'b0;
        res_inx  = 1'b0;
        if (a_nan || b_nan) begin
            res_z   = qnan_c;
            res_nan = 1'b1;
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            res_z   = qnan_c;
            res_nan = 1'b1;
        end else if (a_inf || b_inf) begin
            res_z = inf_c;
        end else if (a_zero || b_zero) begin
            res_z = zero_c;
        end else if (bus.overflow || (zc_exp == EXP_ONES)) begin
            res_z    = ovf_to_inf ? inf_c : max_c;
            res_huge = 1'b1;
            res_inx  = 1'b1;
        end else if (bus.underflow || ((zc_exp == '0) && (zc_man != '0))) begin
            res_z    = unf_to_min ? min_c : zero_c;
            res_tiny = 1'b1;
            res_inx  = 1'b1;
        end else if (zc_exp == '0) begin
            res_z = zero_c;
        end else begin
            res_inx = bus.inexact;
        end
    end

    assign res_zero  = (res_z[W-2:0] == '0);
    assign res_inf   = (res_z[W-2 -: EXP_W] == EXP_ONES) && (res_z[MAN_W-1:0] == '0);
    assign res_flags = {res_inx, res_huge, res_tiny, res_nan, res_inf, res_zero};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            z_reg         <= '0;
            flags_reg     <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept) begin
                out_valid_reg <= 1'b1;
                z_reg         <= res_z;
                flags_reg     <= res_flags;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // A clear coinciding with a transfer wipes history first, then keeps the new result.
    assign exc_bit  = |flags_reg[4:1];
    assign cnt_base = sticky_clr ? '0 : cnt_reg;
    assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(exc_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_reg <= '0;
            cnt_reg    <= '0;
        end else if (xfer) begin
            sticky_reg <= (sticky_clr ? 6'd0 : sticky_reg) | flags_reg;
            cnt_reg    <= cnt_next;
        end else if (sticky_clr) begin
            sticky_reg <= '0;
            cnt_reg    <= '0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.z         = z_reg;
    assign bus.zero_f    = flags_reg[0];
    assign bus.inf_f     = flags_reg[1];
    assign bus.nan_f     = flags_reg[2];
    assign bus.tiny_f    = flags_reg[3];
    assign bus.huge_f    = flags_reg[4];
    assign bus.inexact_f = flags_reg[5];
    assign sticky_flags  = sticky_reg;
    assign exc_count     = cnt_reg;
endmodule

// File: tb/tb_fp_mult_exc_pipe.sv
// Directed plus randomized checks of fp_mult_exc_pipe against a spec-level reference model.
module tb_fp_mult_exc_pipe;
    typedef struct packed {
        logic [31:0] z;
        logic [5:0]  f;   // {inexact,huge,tiny,nan,inf,zero}
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sticky_clr = 1'b0;
    logic [5:0]  sticky_flags;
    logic [15:0] exc_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_valid = 0;
    bit          m_rdy = 0;
    res_t        m_res = '0;
    logic [5:0]  m_sticky = '0;
    logic [15:0] m_cnt = '0;

    fp_mult_exc_pipe_if bus ();

    fp_mult_exc_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .exc_count    (exc_count),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Operand class: 0 zero, 1 normal, 2 infinity, 3 nan
    function automatic int op_class(input logic [31:0] x);
        int e = int'(x[30:23]);
        if (e == 0) return 0;
        if (e == 255) return (x[22:0] == 0) ? 2 : 3;
        return 1;
    endfunction

    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] zc, input logic ov, input logic un,
                                       input logic ix, input logic [2:0] rm);
        res_t r;
        int ca = op_class(a);
        int cb = op_class(b);
        int m = (rm > 5) ? 0 : int'(rm);
        logic s = a[31] ^ b[31];
        int ze = int'(zc[30:23]);
        bit toward_big = (m == 0 || m == 4 || m == 5) || (m == 2 && !s) || (m == 3 && s);
        bit toward_min = (m == 5) || (m == 2 && !s) || (m == 3 && s);
        r.f = '0;
        if (ca == 3 || cb == 3 || (ca == 0 && cb == 2) || (ca == 2 && cb == 0)) begin
            r.z = 32'h7FC00000;
            r.f[2] = 1'b1;
        end else if (ca == 2 || cb == 2) begin
            r.z = {s, 31'h7F800000};
        end else if (ca == 0 || cb == 0) begin
            r.z = {s, 31'h0};
        end else if (ov || ze == 255) begin
            r.z = toward_big ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
            r.f[4] = 1'b1;
            r.f[5] = 1'b1;
        end else if (un || (ze == 0 && zc[22:0] != 0)) begin
            r.z = toward_min ? {s, 31'h00800000} : {s, 31'h0};
            r.f[3] = 1'b1;
            r.f[5] = 1'b1;
        end else if (zc[30:0] == 0) begin
            r.z = {s, 31'h0};
        end else begin
            r.z = zc;
            r.f[5] = ix;
        end
        r.f[0] = (r.z[30:0] == 0);
        r.f[1] = (r.z[30:0] == 31'h7F800000);
        return r;
    endfunction

    // Model advances on each active edge from the bench-driven inputs only.
    always @(posedge clk) begin
        if (rst) begin
            bit xf;
            bit ac;
            xf = m_valid && bus.out_ready;
            ac = bus.in_valid && m_rdy && (!m_valid || bus.out_ready);
            if (xf) begin
                if (sticky_clr) begin
                    m_sticky = '0;
                    m_cnt = '0;
                end
                m_sticky = m_sticky | m_res.f;
                if ((m_res.f[1] || m_res.f[2] || m_res.f[3] || m_res.f[4]) && m_cnt != 16'hFFFF)
                    m_cnt = m_cnt + 16'd1;
            end else if (sticky_clr) begin
                m_sticky = '0;
                m_cnt = '0;
            end
            if (ac) begin
                m_valid = 1;
                m_res = ref_model(bus.a, bus.b, bus.z_calc, bus.overflow, bus.underflow,
                                  bus.inexact, bus.rnd_mode);
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
            m_rdy = 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] dut_flags();
        return {bus.inexact_f, bus.huge_f, bus.tiny_f, bus.nan_f, bus.inf_f, bus.zero_f};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_rdy && (!m_valid || bus.out_ready)));
        if (m_valid) begin
            chk({tag, ".z"}, bus.z, m_res.z);
            chk({tag, ".flags"}, 32'(dut_flags()), 32'(m_res.f));
        end
        chk({tag, ".sticky"}, 32'(sticky_flags), 32'(m_sticky));
        chk({tag, ".count"}, 32'(exc_count), 32'(m_cnt));
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] zc, input logic ov, input logic un, input logic ix,
                         input logic [2:0] rm, input logic ordy, input logic clr);
        bus.in_valid = v;
        bus.a = a;
        bus.b = b;
        bus.z_calc = zc;
        bus.overflow = ov;
        bus.underflow = un;
        bus.inexact = ix;
        bus.rnd_mode = rm;
        bus.out_ready = ordy;
        sticky_clr = clr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Accept one vector, check it one cycle later, then let it drain.
    task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] zc, input logic ov, input logic un,
                            input logic ix, input logic [2:0] rm,
                            input logic [31:0] want_z, input logic [5:0] want_f);
        drive(1, a, b, zc, ov, un, ix, rm, 1, 0);
        step(tag);
        chk({tag, ".plan_z"}, bus.z, want_z);
        chk({tag, ".plan_f"}, 32'(dut_flags()), 32'(want_f));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step({tag, ".drain"});
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] mn;
        logic        sg;
        int c = int'($urandom_range(0, 7));
        sg = 1'($urandom);
        mn = 23'($urandom);
        case (c)
            0: e = 8'd0;
            1: begin e = 8'hFF; mn = '0; end
            2: begin e = 8'hFF; mn = 23'($urandom_range(1, 32'h7FFFFF)); end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {sg, e, mn};
    endfunction

    function automatic logic [31:0] rnd_zc();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:0] = '0;
            1: begin x[30:23] = 8'd0; x[0] = 1'b1; end
            2: x[30:23] = 8'hFF;
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.z", bus.z, 32'd0);
        chk("rst.flags", 32'(dut_flags()), 32'd0);
        chk("rst.sticky", 32'(sticky_flags), 32'd0);
        chk("rst.count", 32'(exc_count), 32'd0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("post_rst");
        chk("post_rst.ready", 32'(bus.in_ready), 32'd1);

        one_shot("norm", 32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 1, 0, 32'h40400000, 6'b100000);
        one_shot("zxinf", 32'h00000000, 32'hFF800000, 32'h0, 0, 0, 1, 0, 32'h7FC00000, 6'b000100);
        one_shot("nan_in", 32'h7F800001, 32'h3F800000, 32'h0, 0, 0, 0, 0, 32'h7FC00000, 6'b000100);
        one_shot("ovf_rz", 32'hFF000000, 32'h7F000000, 32'hFF000000, 1, 0, 1, 1, 32'hFF7FFFFF, 6'b110000);
        one_shot("ovf_rp", 32'hFF000000, 32'h7F000000, 32'hFF000000, 1, 0, 1, 2, 32'hFF7FFFFF, 6'b110000);
        one_shot("ovf_rn", 32'hFF000000, 32'h7F000000, 32'hFF000000, 1, 0, 1, 3, 32'hFF800000, 6'b110010);
        one_shot("unf_ne", 32'h00800000, 32'h00800000, 32'h00000001, 0, 1, 1, 0, 32'h00000000, 6'b101001);
        one_shot("unf_az", 32'h00800000, 32'h00800000, 32'h00000001, 0, 1, 1, 5, 32'h00800000, 6'b101000);
        one_shot("unf_rn", 32'h00800000, 32'h00800000, 32'h00000001, 0, 1, 1, 3, 32'h00000000, 6'b101001);
        one_shot("mode7", 32'h3F800000, 32'h7F000000, 32'h7F800000, 0, 0, 0, 7, 32'h7F800000, 6'b110010);

        // Stall: result must hold while downstream refuses it.
        drive(1, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 0, 1, 0);
        step("hold.load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h40400000, 32'h40400000, 32'h41100000, 0, 0, 0, 0, 0, 0);
            step("hold");
            chk("hold.in_ready0", 32'(bus.in_ready), 32'd0);
            chk("hold.z_stable", bus.z, 32'h40000000);
        end
        // Back-to-back: overflow, normal, nan, then drain with clear.
        drive(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 1, 0, 1, 0);
        step("b2b.1");
        drive(1, 32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 0, 0, 1, 0);
        step("b2b.2");
        drive(1, 32'h7FC00000, 32'h40000000, 32'h0, 0, 0, 0, 0, 1, 0);
        step("b2b.3");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("b2b.clr");
        chk("b2b.clr_count", 32'(exc_count), 32'd1);
        chk("b2b.clr_sticky", 32'(sticky_flags), 32'b000100);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), rnd_zc(),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom),
                  3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
            step("rand");
        end

        // Reset while a result is stalled.
        drive(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 1, 0, 0, 0);
        step("mid.load");
        drive(1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 1, 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        m_valid = 0;
        m_rdy = 0;
        m_sticky = '0;
        m_cnt = '0;
        #1;
        chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid.sticky", 32'(sticky_flags), 32'd0);
        chk("mid.count", 32'(exc_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mid.release");
        chk("mid.ready", 32'(bus.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
